// File: rtl/acoustics_uart_rx_if.sv
// Serial line and received-byte strobes between the UART receiver and its consumer.
interface acoustics_uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_ready,
        output rx_data,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_ready,
        input  rx_data,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/acoustics_uart_rx.sv
// 8N1 UART receiver for the PC command link; one-cycle rx_ready / rx_frame_err strobes.
// Define ACOUSTICS_UART_RX_MAJORITY_EN for 3-sample majority voting at each sample point.
module acoustics_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                clk,
    input  logic                reset_b,
    acoustics_uart_rx_if.master bus
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
`ifdef ACOUSTICS_UART_RX_MAJORITY_EN
    // Vote is resolved one cycle after the nominal point, so the start phase is one longer.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
`endif
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    logic [1:0]       sync;
    logic             rx_s;
    logic             samp;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) sync <= 2'b11;
        else          sync <= {sync[0], bus.rx};
    end

`ifdef ACOUSTICS_UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) hist <= 2'b11;
        else          hist <= {hist[0], rx_s};
    end

    // Majority of rx_s at the previous three cycles, centred on the cycle before this one.
    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state            <= IDLE;
            clk_cnt          <= '0;
            bit_cnt          <= '0;
            shift            <= '0;
            bus.rx_data      <= 8'h00;
            bus.rx_ready     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_busy      <= 1'b0;
        end else begin
            bus.rx_ready     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state       <= START;
                        bus.rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == START_LAST) begin
                        clk_cnt <= '0;
                        if (!samp) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            bus.rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt        <= '0;
                        shift[bit_cnt] <= samp;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (samp) begin
                            bus.rx_data  <= shift;
                            bus.rx_ready <= 1'b1;
                            bus.rx_busy  <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            bus.rx_frame_err <= 1'b1;
                            state            <= BRK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                BRK: begin
                    // Held-low line: stay here silently until it returns high.
                    if (rx_s) begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
